// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package periph_bus_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_SLV = 4;
    localparam int unsigned WAIT_W  = 3;

    localparam int unsigned SEL_DRAM = 0;
    localparam int unsigned SEL_SW   = 1;
    localparam int unsigned SEL_LED  = 2;
    localparam int unsigned SEL_DIG  = 3;

    localparam logic [11:0] OFS_DIG = 12'h000;
    localparam logic [11:0] OFS_LED = 12'h060;
    localparam logic [11:0] OFS_SW  = 12'h070;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Master-side and slave-side signals of the peripheral bus arbiter.
interface periph_bus_arbiter_if;
    import periph_bus_pkg::*;

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic [NUM_SLV-1:0] s_sel;
    logic               s_we;
    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_wdata;
    logic [DATA_W-1:0]  s_rdata_dram;
    logic [DATA_W-1:0]  s_rdata_sw;
    logic [DATA_W-1:0]  s_rdata_led;
    logic [DATA_W-1:0]  s_rdata_dig;
    logic               bus_err;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  s_rdata_dram, s_rdata_sw, s_rdata_led, s_rdata_dig,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output s_sel, s_we, s_addr, s_wdata, bus_err
    );

    // Environment view: bus masters plus slave read data
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output s_rdata_dram, s_rdata_sw, s_rdata_led, s_rdata_dig,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  s_sel, s_we, s_addr, s_wdata, bus_err
    );

endinterface

// File: rtl/periph_addr_decode.sv
// Byte address to one-hot slave select; unmapped I/O offsets select nothing.
module periph_addr_decode
    import periph_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IO_BASE = 32'hFFFF_F000
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel_c,
    output logic               o_unmapped_c
);

    always_comb begin
        o_sel_c      = '0;
        o_unmapped_c = 1'b0;
        if (i_addr < IO_BASE) begin
            o_sel_c[SEL_DRAM] = 1'b1;
        end else begin
            case (i_addr[11:0])
                OFS_SW:  o_sel_c[SEL_SW]  = 1'b1;
                OFS_LED: o_sel_c[SEL_LED] = 1'b1;
                OFS_DIG: o_sel_c[SEL_DIG] = 1'b1;
                default: o_unmapped_c     = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master, four-slave peripheral bus controller: round-robin grant,
// one access at a time with per-slave wait states, registered response.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int unsigned       DRAM_WAIT = 1,
    parameter int unsigned       IO_WAIT   = 0,
    parameter logic [ADDR_W-1:0] IO_BASE   = 32'hFFFF_F000
) (
    input logic                 clk,
    input logic                 rst,
    periph_bus_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] DRAM_WAIT_L = WAIT_W'(DRAM_WAIT);
    localparam logic [WAIT_W-1:0] IO_WAIT_L   = WAIT_W'(IO_WAIT);

    state_e              r_state, w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_win, w_win_nxt;
    logic                r_we, w_we_nxt;
    logic                r_unmapped, w_unmapped_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic [NUM_SLV-1:0]  r_s_sel, w_s_sel_nxt;
    logic                r_s_we, w_s_we_nxt;
    logic [ADDR_W-1:0]   r_s_addr, w_s_addr_nxt;
    logic [DATA_W-1:0]   r_s_wdata, w_s_wdata_nxt;
    logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nxt;
    logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nxt;
    logic                r_m0_ack, w_m0_ack_nxt;
    logic                r_m1_ack, w_m1_ack_nxt;
    logic                r_bus_err, w_bus_err_nxt;

    logic                w_pick;
    bus_req_t            w_req;
    logic [NUM_SLV-1:0]  w_dec_sel;
    logic                w_dec_unmapped;
    logic [WAIT_W-1:0]   w_wait_load;
    logic [DATA_W-1:0]   w_slv_rdata;
    logic                w_finish;

    // Under contention the master not served last wins, giving strict alternation
    assign w_pick = (bus.m0_req && bus.m1_req) ? ~r_last_grant : bus.m1_req;
    assign w_req  = w_pick ? bus_req_t'{bus.m1_we, bus.m1_addr, bus.m1_wdata}
                           : bus_req_t'{bus.m0_we, bus.m0_addr, bus.m0_wdata};

    periph_addr_decode #(
        .IO_BASE (IO_BASE)
    ) u_decode (
        .i_addr       (w_req.addr),
        .o_sel_c      (w_dec_sel),
        .o_unmapped_c (w_dec_unmapped)
    );

    assign w_wait_load = r_s_sel[SEL_DRAM] ? DRAM_WAIT_L : IO_WAIT_L;

    // Unmapped accesses have no select bit set and therefore read back zero
    always_comb begin
        w_slv_rdata = '0;
        if (r_s_sel[SEL_DRAM])     w_slv_rdata = bus.s_rdata_dram;
        else if (r_s_sel[SEL_SW])  w_slv_rdata = bus.s_rdata_sw;
        else if (r_s_sel[SEL_LED]) w_slv_rdata = bus.s_rdata_led;
        else if (r_s_sel[SEL_DIG]) w_slv_rdata = bus.s_rdata_dig;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_win_nxt        = r_win;
        w_we_nxt         = r_we;
        w_unmapped_nxt   = r_unmapped;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_s_sel_nxt      = r_s_sel;
        w_s_we_nxt       = 1'b0;
        w_s_addr_nxt     = r_s_addr;
        w_s_wdata_nxt    = r_s_wdata;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;
        w_m0_ack_nxt     = 1'b0;
        w_m1_ack_nxt     = 1'b0;
        w_bus_err_nxt    = 1'b0;
        w_finish         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    w_state_nxt      = ST_ACCESS;
                    w_last_grant_nxt = w_pick;
                    w_win_nxt        = w_pick;
                    w_we_nxt         = w_req.we;
                    w_unmapped_nxt   = w_dec_unmapped;
                    w_s_sel_nxt      = w_dec_sel;
                    w_s_we_nxt       = w_req.we && !w_dec_unmapped;
                    w_s_addr_nxt     = w_req.addr;
                    w_s_wdata_nxt    = w_req.wdata;
                end
            end
            ST_ACCESS: begin
                w_wait_cnt_nxt = w_wait_load;
                if (w_wait_load == '0) w_finish    = 1'b1;
                else                   w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt <= WAIT_W'(1)) w_finish       = 1'b1;
                else                          w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // Response is registered on entry to DONE, so ack and rdata are seen in DONE
        if (w_finish) begin
            w_state_nxt   = ST_DONE;
            w_s_sel_nxt   = '0;
            w_bus_err_nxt = r_unmapped;
            if (r_win) begin
                w_m1_ack_nxt = 1'b1;
                if (!r_we) w_m1_rdata_nxt = w_slv_rdata;
            end else begin
                w_m0_ack_nxt = 1'b1;
                if (!r_we) w_m0_rdata_nxt = w_slv_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_win        <= 1'b0;
            r_we         <= 1'b0;
            r_unmapped   <= 1'b0;
            r_wait_cnt   <= '0;
            r_s_sel      <= '0;
            r_s_we       <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_win        <= w_win_nxt;
            r_we         <= w_we_nxt;
            r_unmapped   <= w_unmapped_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_s_sel      <= w_s_sel_nxt;
            r_s_we       <= w_s_we_nxt;
            r_s_addr     <= w_s_addr_nxt;
            r_s_wdata    <= w_s_wdata_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
            r_m0_ack     <= w_m0_ack_nxt;
            r_m1_ack     <= w_m1_ack_nxt;
            r_bus_err    <= w_bus_err_nxt;
        end
    end

    assign bus.s_sel    = r_s_sel;
    assign bus.s_we     = r_s_we;
    assign bus.s_addr   = r_s_addr;
    assign bus.s_wdata  = r_s_wdata;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.m0_ack   = r_m0_ack;
    assign bus.m1_ack   = r_m1_ack;
    assign bus.bus_err  = r_bus_err;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter (DRAM_WAIT=1, IO_WAIT=0).
module tb_periph_bus_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    // Per-access observations filled by do_access
    int          g_lat;
    int          g_sel_cyc;
    logic [3:0]  g_sel_or;
    int          g_we_cyc;
    logic [31:0] g_wd;
    logic [31:0] g_wa;
    int          g_other_ack;
    int          g_err_cnt;
    logic        g_err_at_ack;
    logic [31:0] g_rdata;

    periph_bus_arbiter_if bus();

    periph_bus_arbiter #(
        .DRAM_WAIT (1),
        .IO_WAIT   (0),
        .IO_BASE   (32'hFFFF_F000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit m, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
    endtask

    // Starts at a negedge in IDLE, returns at a negedge of the following IDLE cycle
    task automatic do_access(input bit m, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int   t0;
        bit   done;
        logic my_ack;
        logic ot_ack;
        set_req(m, 1'b1, we, addr, wdata);
        t0 = cyc; done = 0;
        g_lat = -1; g_sel_cyc = 0; g_sel_or = '0; g_we_cyc = 0; g_wd = '0; g_wa = '0;
        g_other_ack = 0; g_err_cnt = 0; g_err_at_ack = 1'b0; g_rdata = 'x;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            my_ack = m ? bus.m1_ack : bus.m0_ack;
            ot_ack = m ? bus.m0_ack : bus.m1_ack;
            if (bus.s_sel != 4'b0000) begin g_sel_cyc++; g_sel_or |= bus.s_sel; end
            if (bus.s_we) begin g_we_cyc++; g_wd = bus.s_wdata; g_wa = bus.s_addr; end
            if (bus.bus_err) g_err_cnt++;
            if (ot_ack) g_other_ack++;
            if (my_ack) begin
                g_lat        = cyc - t0;
                g_rdata      = m ? bus.m1_rdata : bus.m0_rdata;
                g_err_at_ack = bus.bus_err;
                done         = 1;
                set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        if (!done) set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    // Collect the master index of the next n acks while the caller holds requests
    task automatic collect(input int n, output logic [7:0] order, output int got, output int both);
        got = 0; order = '0; both = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(negedge clk);
            if (bus.m0_ack && bus.m1_ack) both++;
            if (bus.m0_ack) begin order[got] = 1'b0; got++; end
            else if (bus.m1_ack) begin order[got] = 1'b1; got++; end
            if (got == n) begin
                set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'(bus.s_sel),    32'h0);
        check({tag, "_we"},    32'(bus.s_we),     32'h0);
        check({tag, "_addr"},  bus.s_addr,        32'h0);
        check({tag, "_wdata"}, bus.s_wdata,       32'h0);
        check({tag, "_ack0"},  32'(bus.m0_ack),   32'h0);
        check({tag, "_ack1"},  32'(bus.m1_ack),   32'h0);
        check({tag, "_err"},   32'(bus.bus_err),  32'h0);
        check({tag, "_rd0"},   bus.m0_rdata,      32'h0);
        check({tag, "_rd1"},   bus.m1_rdata,      32'h0);
    endtask

    initial begin
        logic [7:0] order;
        int         got;
        int         both;
        int         stray;

        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.s_rdata_dram = 32'hDEAD_BEEF;
        bus.s_rdata_sw   = 32'h1111_0070;
        bus.s_rdata_led  = 32'h2222_0060;
        bus.s_rdata_dig  = 32'h3333_0000;

        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // m0 DRAM read with one wait state
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        check("dram_rd_lat",   32'(g_lat),       32'd3);
        check("dram_rd_selc",  32'(g_sel_cyc),   32'd2);
        check("dram_rd_sel",   32'(g_sel_or),    32'h1);
        check("dram_rd_we",    32'(g_we_cyc),    32'd0);
        check("dram_rd_data",  g_rdata,          32'hDEAD_BEEF);
        check("dram_rd_oack",  32'(g_other_ack), 32'd0);

        // m1 LED write
        do_access(1'b1, 1'b1, 32'hFFFF_F060, 32'h00A5_00FF);
        check("led_wr_lat",    32'(g_lat),       32'd2);
        check("led_wr_selc",   32'(g_sel_cyc),   32'd1);
        check("led_wr_sel",    32'(g_sel_or),    32'h4);
        check("led_wr_we",     32'(g_we_cyc),    32'd1);
        check("led_wr_wdata",  g_wd,             32'h00A5_00FF);
        check("led_wr_oack",   32'(g_other_ack), 32'd0);
        check("led_wr_rd1",    g_rdata,          32'h0);

        // m1 switch read, m0 digtube read
        do_access(1'b1, 1'b0, 32'hFFFF_F070, 32'h0);
        check("sw_rd_lat",     32'(g_lat),       32'd2);
        check("sw_rd_sel",     32'(g_sel_or),    32'h2);
        check("sw_rd_data",    g_rdata,          32'h1111_0070);
        do_access(1'b0, 1'b0, 32'hFFFF_F000, 32'h0);
        check("dig_rd_sel",    32'(g_sel_or),    32'h8);
        check("dig_rd_data",   g_rdata,          32'h3333_0000);

        // m0 DRAM write leaves m0_rdata untouched
        do_access(1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
        check("dram_wr_lat",   32'(g_lat),       32'd3);
        check("dram_wr_we",    32'(g_we_cyc),    32'd1);
        check("dram_wr_wdata", g_wd,             32'hCAFE_F00D);
        check("dram_wr_waddr", g_wa,             32'h0000_0100);
        check("dram_wr_rd0",   g_rdata,          32'h3333_0000);

        // Unmapped read and write
        do_access(1'b0, 1'b0, 32'hFFFF_F004, 32'h0);
        check("unm_rd_lat",    32'(g_lat),        32'd2);
        check("unm_rd_selc",   32'(g_sel_cyc),    32'd0);
        check("unm_rd_err",    32'(g_err_at_ack), 32'd1);
        check("unm_rd_errc",   32'(g_err_cnt),    32'd1);
        check("unm_rd_data",   g_rdata,           32'h0);
        do_access(1'b1, 1'b1, 32'hFFFF_F100, 32'h1234_5678);
        check("unm_wr_we",     32'(g_we_cyc),     32'd0);
        check("unm_wr_selc",   32'(g_sel_cyc),    32'd0);
        check("unm_wr_err",    32'(g_err_at_ack), 32'd1);
        check("unm_wr_rd1",    g_rdata,           32'h1111_0070);

        // Both masters request continuously after reset: m0, m1, m0, m1
        apply_reset();
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'hFFFF_F070, 32'h0);
        collect(4, order, got, both);
        check("alt_count",     32'(got),         32'd4);
        check("alt_order",     32'(order[3:0]),  32'hA);
        check("alt_both_ack",  32'(both),        32'd0);
        @(negedge clk);

        // m0 holds req through its ack while m1 waits: m0, m1, m0
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 32'hFFFF_F060, 32'h0);
        collect(3, order, got, both);
        check("hold_count",    32'(got),         32'd3);
        check("hold_order",    32'(order[2:0]),  32'h2);
        check("hold_rd1",      bus.m1_rdata,     32'h2222_0060);
        @(negedge clk);

        // Reset while a DRAM read sits in WAIT
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_wait_sel", 32'(bus.s_sel),  32'h1);
        check("abort_wait_we",  32'(bus.s_we),   32'h0);
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack) stray++;
        end
        check("abort_no_ack",  32'(stray),       32'd0);
        do_access(1'b1, 1'b0, 32'hFFFF_F060, 32'h0);
        check("post_rst_lat",  32'(g_lat),       32'd2);
        check("post_rst_data", g_rdata,          32'h2222_0060);
        check("post_rst_oack", 32'(g_other_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master, four-slave controller for the SoC peripheral bus.
- Arbitrates between the miniRV data port (master 0) and a secondary master (master 1, e.g. a UART program loader or debug DMA).
- Decodes the address to DRAM, switch, LED or digtube, sequences one access at a time with a per-slave wait count, and returns a registered read-data/ack response.
- Sits between the masters and the existing DRAM/LED/Digtube/Switch blocks, all clocked by the CPU clock.

Parameters:
- DRAM_WAIT, 1, extra wait cycles before a DRAM access completes (0..7)
- IO_WAIT, 0, extra wait cycles for switch/LED/digtube accesses (0..7)
- IO_BASE, 32'hFFFF_F000, start of the I/O region; addresses below it select DRAM

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  master 0 access request; held until m0_ack
- m0_we  in  1  master 0 write enable
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data; valid with m0_ack
- m0_ack  out  1  one-cycle completion pulse for master 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1
- s_sel  out  4  one-hot slave select: bit0 DRAM, bit1 switch, bit2 LED, bit3 digtube
- s_we  out  1  write strobe to the selected slave
- s_addr  out  32  address to the slaves
- s_wdata  out  32  write data to the slaves
- s_rdata_dram, s_rdata_sw, s_rdata_led, s_rdata_dig  in  32 each  slave read data (combinational)
- bus_err  out  1  one-cycle pulse when an unmapped I/O address completes

Behaviour:
- Reset, applied on any rising clk with rst=1:
  - state goes to IDLE.
  - s_sel, s_we, s_addr, s_wdata, m0_rdata, m1_rdata all go to 0.
  - m0_ack, m1_ack and bus_err go to 0.
  - last_grant goes to 1, so master 0 wins the first contention.
  - A reset mid-access aborts it silently: no ack is issued and the access is never retried.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high, pick a winner:
    - Only one requester: it wins.
    - Both requesting: the master that is not last_grant wins.
  - Latch the winner index, addr, we and wdata into bus registers. Set last_grant to the winner. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive s_sel from the decoded address, plus s_addr and s_wdata.
  - s_we = latched we, asserted only in this cycle, so a write lands exactly once.
  - Load wait_cnt with DRAM_WAIT if the DRAM is selected, otherwise IO_WAIT.
  - If wait_cnt would be 0, go to DONE; otherwise go to WAIT.
- WAIT:
  - s_sel and s_addr are held; s_we = 0.
  - wait_cnt decrements each cycle; go to DONE when it reaches 1.
- DONE (1 cycle):
  - Capture the selected slave's s_rdata into the winner's mN_rdata.
  - Pulse the winner's mN_ack. The other master's rdata is unchanged.
  - s_sel goes to 0. Return to IDLE.
- Latency with 0 waits: req sampled in IDLE at cycle T, ack at T+2 (T+2+waits in general). The next access starts no earlier than T+3.
- Master rules:
  - A master keeps req, addr, we and wdata stable until its ack.
  - It must drop req in the ack cycle, or it is treated as a new request in IDLE.
  - The arbiter latches its inputs, so later changes to them do not affect an access already in progress.
- Decode, on latched addr:
  - addr < IO_BASE: DRAM.
  - addr[11:0] = 12'h070: switch.
  - 12'h060: LED.
  - 12'h000: digtube.
  - Any other I/O address is unmapped:
    - s_sel = 0 and no write reaches any slave.
    - It completes with rdata = 0, and bus_err pulses together with the ack.
- Writes complete with the corresponding mN_rdata unchanged.
- Simultaneous requests: exactly one ack per access, with strict alternation while both masters stay busy. A master is never granted twice while the other is waiting.

Decomposition:
- Package periph_bus_pkg:
  - FSM state encoding.
  - Slave-index constants SEL_DRAM=0, SEL_SW=1, SEL_LED=2, SEL_DIG=3.
  - I/O offset constants 12'h000, 12'h060, 12'h070.
- One sub-module, periph_addr_decode: combinational address to one-hot select plus an unmapped flag.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single m0 read of DRAM 0x0000_0010, s_rdata_dram=32'hDEAD_BEEF, DRAM_WAIT=1 -> s_sel=4'b0001 for 2 cycles; m0_ack at T+3 with m0_rdata=DEADBEEF; s_we never 1.
- m1 write of 32'h00A5_00FF to 0xFFFF_F060 -> s_sel=4'b0100 and s_we=1 for exactly one cycle with s_wdata=00A500FF; m1_ack at T+2; m0_ack stays 0.
- m0 and m1 both request continuously for 4 accesses after reset -> grant order m0, m1, m0, m1, with acks alternating.
- m0 read of 0xFFFF_F004 (unmapped) -> s_sel stays 0; m0_ack and bus_err pulse together; m0_rdata=0.
- rst asserted while in WAIT during a DRAM read -> next cycle state IDLE with all outputs 0, no ack ever issued; a fresh m1 request is then served with ack at T+2 (after WAIT at 0).
- m0 keeps req high through its ack cycle while m1 is also requesting -> m1 is granted next; m0 is served after m1.
